// File: rtl/pcs_rx_symbol_aligner.sv
// pcs_rx_symbol_aligner: 10BASE-T1S PCS receive front end.
// Hunts for the J/SYNC code in the recovered bit stream and packs bits into
// 5B symbols. It presents each symbol on RXn with a three-deep history and an
// RSCD strobe. While the line is quiet it synthesises SILENCE symbols.
// Optional feature (define RX_ALIGN_LOSS_DET_EN): invalid-symbol counting in
// LOCKED, which drops back to HUNT after LOSS_THRESH consecutive bad codes.
module pcs_rx_symbol_aligner #(
  parameter logic [4:0]  SYNC_CODE      = 5'b11000,
  parameter logic [4:0]  SILENCE_CODE   = 5'b11111,
  parameter int unsigned SILENCE_PERIOD = 10,
  parameter int unsigned LOSS_THRESH    = 4
) (
  input  logic       clk,
  input  logic       pcs_reset,
  input  logic       rx_bit,
  input  logic       rx_bit_valid,
  input  logic       signal_present,
  output logic       RSCD,
  output logic [4:0] RXn,
  output logic [4:0] RXn_1,
  output logic [4:0] RXn_2,
  output logic [4:0] RXn_3,
  output logic       aligned,
  output logic       align_loss
);

  localparam int SIL_W = (SILENCE_PERIOD > 1) ? $clog2(SILENCE_PERIOD) : 1;
  localparam logic [SIL_W-1:0] SIL_LAST = SIL_W'(SILENCE_PERIOD - 1);

  typedef enum logic [1:0] {HUNT, LOCKED, SILENT} state_t;

  state_t           state_q, state_d;
  logic [4:0]       sr_q, sr_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [SIL_W-1:0] sil_q, sil_d;
  logic [4:0]       sr_shift;
  logic             emit;
  logic [4:0]       emit_sym;
  logic             loss;

`ifdef RX_ALIGN_LOSS_DET_EN
  localparam int ERR_W = $clog2(LOSS_THRESH + 1);
  logic [ERR_W-1:0] err_q, err_d;

  // Codes the receive state diagram can legitimately see on the line.
  function automatic logic sym_valid(input logic [4:0] s);
    case (s)
      5'b11110, 5'b01001, 5'b10100, 5'b10101,
      5'b01010, 5'b01011, 5'b01110, 5'b01111,
      5'b10010, 5'b10011, 5'b10110, 5'b10111,
      5'b11010, 5'b11011, 5'b11100, 5'b11101,
      5'b11111, 5'b11000, 5'b10001, 5'b01101,
      5'b00111, 5'b00100: sym_valid = 1'b1;
      default:            sym_valid = 1'b0;
    endcase
  endfunction

  // Consecutive-invalid-symbol counter.
  always_ff @(posedge clk) begin
    if (pcs_reset) err_q <= '0;
    else           err_q <= err_d;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (pcs_reset) state_q <= HUNT;
    else           state_q <= state_d;
  end

  // Next state, bit assembly, silence timer and emit decision.
  // A low signal_present outranks any strobe in the same cycle.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    bitcnt_d = bitcnt_q;
    sil_d    = sil_q;
    sr_shift = {sr_q[3:0], rx_bit};
    emit     = 1'b0;
    emit_sym = sr_shift;
    loss     = 1'b0;
`ifdef RX_ALIGN_LOSS_DET_EN
    err_d    = err_q;
`endif
    case (state_q)
      HUNT: begin
        if (!signal_present) begin
          state_d  = SILENT;
          emit     = 1'b1;
          emit_sym = SILENCE_CODE;
          sil_d    = '0;
        end else if (rx_bit_valid) begin
          sr_d = sr_shift;
          if (sr_shift == SYNC_CODE) begin
            emit     = 1'b1;
            bitcnt_d = 3'd0;
            state_d  = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (!signal_present) begin
          // The partial symbol is dropped; HUNT restarts from a clean register.
          state_d  = SILENT;
          emit     = 1'b1;
          emit_sym = SILENCE_CODE;
          loss     = 1'b1;
          sil_d    = '0;
          sr_d     = '0;
          bitcnt_d = 3'd0;
`ifdef RX_ALIGN_LOSS_DET_EN
          err_d    = '0;
`endif
        end else if (rx_bit_valid) begin
          sr_d = sr_shift;
          if (bitcnt_q == 3'd4) begin
            bitcnt_d = 3'd0;
            emit     = 1'b1;
`ifdef RX_ALIGN_LOSS_DET_EN
            if (!sym_valid(sr_shift)) begin
              if (32'(err_q) + 32'd1 >= LOSS_THRESH) begin
                // The offending symbol still goes out; alignment is dropped after it.
                state_d = HUNT;
                loss    = 1'b1;
                err_d   = '0;
              end else begin
                err_d = err_q + ERR_W'(1);
              end
            end else begin
              err_d = '0;
            end
`endif
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
      end
      SILENT: begin
        if (signal_present) begin
          state_d  = HUNT;
          sr_d     = '0;
          bitcnt_d = 3'd0;
          sil_d    = '0;
        end else if (sil_q == SIL_LAST) begin
          sil_d    = '0;
          emit     = 1'b1;
          emit_sym = SILENCE_CODE;
        end else begin
          sil_d = sil_q + SIL_W'(1);
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // FSM output: lock indication follows the state directly.
  always_comb begin
    aligned = (state_q == LOCKED);
  end

  // Datapath registers: shift register, counters and the symbol history.
  always_ff @(posedge clk) begin
    if (pcs_reset) begin
      sr_q       <= '0;
      bitcnt_q   <= 3'd0;
      sil_q      <= '0;
      RSCD       <= 1'b0;
      align_loss <= 1'b0;
      RXn        <= SILENCE_CODE;
      RXn_1      <= SILENCE_CODE;
      RXn_2      <= SILENCE_CODE;
      RXn_3      <= SILENCE_CODE;
    end else begin
      sr_q       <= sr_d;
      bitcnt_q   <= bitcnt_d;
      sil_q      <= sil_d;
      RSCD       <= emit;
      align_loss <= loss;
      if (emit) begin
        RXn_3 <= RXn_2;
        RXn_2 <= RXn_1;
        RXn_1 <= RXn;
        RXn   <= emit_sym;
      end
    end
  end

endmodule
